mem_wb_pipe: RTL

//  Dual-lane MEM stage plus MEM/WB register; directly consumes the EX/MEM lane outputs of the dual-issue pipe.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/mem_wb_pipe_if.sv | 48 ++++
 rtl/mem_wb_pipe_dmem_sp.sv | 26 ++
 rtl/mem_wb_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the dual-lane MEM stage and MEM/WB register.
// Latency: n/a (package). Backpressure: n/a.
// Contents: width constants, MEM-stage FSM state, per-lane EX/MEM and MEM/WB records.
package pipe_pkg;

  localparam int ADDR_W = 10;  // data-memory word address width
  localparam int DATA_W = 32;  // data word width
  localparam int RA_W   = 10;  // jal link value width
  localparam int REG_W  = 5;   // register index width

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } mem_state_t;

  // One lane's EX/MEM fields as seen by the MEM stage.
  typedef struct packed {
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] store_dat;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_to_reg;
    logic              reg_wr;
    logic              jal;
    logic [REG_W-1:0]  dest;
    logic [RA_W-1:0]   ra;
  } mem_lane_t;

  // One lane's MEM/WB register contents. use_hold selects the lane's hold
  // register instead of the live RAM read port as the load-data source.
  typedef struct packed {
    logic              reg_wr;
    logic [REG_W-1:0]  dest;
    logic              jal;
    logic              mem_to_reg;
    logic [DATA_W-1:0] alu_res;
    logic [RA_W-1:0]   ra;
    logic              use_hold;
  } wb_lane_t;

  function automatic logic [DATA_W-1:0] zext_ra(input logic [RA_W-1:0] ra);
    return {{(DATA_W-RA_W){1'b0}}, ra};
  endfunction

  function automatic logic touches_mem(input mem_lane_t l);
    return l.mem_rd | l.mem_wr;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// Bundle of EX/MEM lane inputs and MEM/WB / forwarding outputs for mem_wb_pipe.
// Latency: n/a (wiring only). Backpressure: stall_o from the slave holds the master's bundle.
// Ports: master = EX/MEM side (drives lane fields, sees stall and results); slave = mem_wb_pipe.
interface mem_wb_pipe_if;
  import pipe_pkg::*;

  logic              stall_o;

  logic [DATA_W-1:0] aluRes1_MEM, aluRes2_MEM;
  logic [DATA_W-1:0] forwardBRes1_MEM, forwardBRes2_MEM;
  logic              MemReadEn1_MEM, MemReadEn2_MEM;
  logic              MemWriteEn1_MEM, MemWriteEn2_MEM;
  logic              MemtoReg1_MEM, MemtoReg2_MEM;
  logic              RegWriteEn1_MEM, RegWriteEn2_MEM;
  logic              jal1_MEM, jal2_MEM;
  logic [REG_W-1:0]  DestReg1_MEM, DestReg2_MEM;
  logic [RA_W-1:0]   return_addr1_MEM, return_addr2_MEM;

  logic [DATA_W-1:0] aluRes1_MEM_fwd, aluRes2_MEM_fwd;
  logic              regWrite1_WB, regWrite2_WB;
  logic [REG_W-1:0]  writeReg1_WB, writeReg2_WB;
  logic              jal1_WB, jal2_WB;
  logic [DATA_W-1:0] aluRes1_WB, aluRes2_WB;
  logic [DATA_W-1:0] writeData1_WB, writeData2_WB;

  modport master (
    output aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM,
           MemReadEn1_MEM, MemReadEn2_MEM, MemWriteEn1_MEM, MemWriteEn2_MEM,
           MemtoReg1_MEM, MemtoReg2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM,
           jal1_MEM, jal2_MEM, DestReg1_MEM, DestReg2_MEM,
           return_addr1_MEM, return_addr2_MEM,
    input  stall_o, aluRes1_MEM_fwd, aluRes2_MEM_fwd,
           regWrite1_WB, regWrite2_WB, writeReg1_WB, writeReg2_WB,
           jal1_WB, jal2_WB, aluRes1_WB, aluRes2_WB, writeData1_WB, writeData2_WB
  );

  modport slave (
    input  aluRes1_MEM, aluRes2_MEM, forwardBRes1_MEM, forwardBRes2_MEM,
           MemReadEn1_MEM, MemReadEn2_MEM, MemWriteEn1_MEM, MemWriteEn2_MEM,
           MemtoReg1_MEM, MemtoReg2_MEM, RegWriteEn1_MEM, RegWriteEn2_MEM,
           jal1_MEM, jal2_MEM, DestReg1_MEM, DestReg2_MEM,
           return_addr1_MEM, return_addr2_MEM,
    output stall_o, aluRes1_MEM_fwd, aluRes2_MEM_fwd,
           regWrite1_WB, regWrite2_WB, writeReg1_WB, writeReg2_WB,
           jal1_WB, jal2_WB, aluRes1_WB, aluRes2_WB, writeData1_WB, writeData2_WB
  );

endinterface

// File: rtl/mem_wb_pipe_dmem_sp.sv
// Single-port synchronous data RAM: write on the clock edge, registered read.
// Latency: read data valid 1 cycle after the address is presented. Backpressure: none.
// Ports: clk, we, addr, wdata in; rdata out (read-old-data when writing the same word).
module dmem_sp #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// Dual-lane MEM stage + MEM/WB register sharing one single-port data RAM.
// Latency: 1 cycle; 2 cycles when both lanes touch memory (lane 1 first, then lane 2).
// Backpressure: stall_o=1 for the first cycle of a serialised bundle; EX/MEM must hold its inputs.
// Ports: clk, rst (async active-high), bus (mem_wb_pipe_if.slave).
// Build option: STORE_LOAD_FWD_EN lets a lane-1 store / lane-2 load pair to the same
// word complete in one cycle by forwarding the store data to lane 2.
module mem_wb_pipe
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_wb_pipe_if.slave bus
);

  mem_lane_t  l1, l2;
  mem_state_t state_q, state_d;
  wb_lane_t   wb1_q, wb1_d, wb2_q, wb2_d;
  logic [DATA_W-1:0] hold1_q, hold1_d, hold2_q, hold2_d;

  logic              stall;
  logic              acc_sel_l2;
  logic              fwd_hit;
  logic              conflict;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [DATA_W-1:0] ld1, ld2;

  always_comb begin
    l1            = '0;
    l1.alu_res    = bus.aluRes1_MEM;
    l1.store_dat  = bus.forwardBRes1_MEM;
    l1.mem_rd     = bus.MemReadEn1_MEM;
    l1.mem_wr     = bus.MemWriteEn1_MEM;
    l1.mem_to_reg = bus.MemtoReg1_MEM;
    l1.reg_wr     = bus.RegWriteEn1_MEM;
    l1.jal        = bus.jal1_MEM;
    l1.dest       = bus.DestReg1_MEM;
    l1.ra         = bus.return_addr1_MEM;
    l2            = '0;
    l2.alu_res    = bus.aluRes2_MEM;
    l2.store_dat  = bus.forwardBRes2_MEM;
    l2.mem_rd     = bus.MemReadEn2_MEM;
    l2.mem_wr     = bus.MemWriteEn2_MEM;
    l2.mem_to_reg = bus.MemtoReg2_MEM;
    l2.reg_wr     = bus.RegWriteEn2_MEM;
    l2.jal        = bus.jal2_MEM;
    l2.dest       = bus.DestReg2_MEM;
    l2.ra         = bus.return_addr2_MEM;
  end

  function automatic wb_lane_t mk_wb(input mem_lane_t l, input logic use_hold);
    wb_lane_t w;
    w            = '0;
    w.reg_wr     = l.reg_wr;
    w.dest       = l.dest;
    w.jal        = l.jal;
    w.mem_to_reg = l.mem_to_reg;
    w.alu_res    = l.alu_res;
    w.ra         = l.ra;
    w.use_hold   = use_hold;
    return w;
  endfunction

`ifdef STORE_LOAD_FWD_EN
  // Pure store (lane 1) followed by pure load (lane 2) of the same word:
  // lane 2's result is exactly lane 1's store data, so no second access is needed.
  assign fwd_hit = l1.mem_wr & ~l1.mem_rd & l2.mem_rd & ~l2.mem_wr &
                   (l1.alu_res[ADDR_W-1:0] == l2.alu_res[ADDR_W-1:0]);
`else
  assign fwd_hit = 1'b0;
`endif

  assign conflict = touches_mem(l1) & touches_mem(l2) & ~fwd_hit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wb1_q   <= '0;
      wb2_q   <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      state_q <= state_d;
      wb1_q   <= wb1_d;
      wb2_q   <= wb2_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (conflict) state_d = SERIAL;
      SERIAL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    stall      = 1'b0;
    acc_sel_l2 = 1'b0;
    wb1_d      = '0;
    wb2_d      = '0;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    case (state_q)
      IDLE: begin
        if (conflict) begin
          // Lane 1 accesses now; WB gets a bubble until lane 2 finishes.
          stall = 1'b1;
        end else begin
          acc_sel_l2 = ~touches_mem(l1);
          wb1_d      = mk_wb(l1, 1'b0);
          wb2_d      = mk_wb(l2, fwd_hit);
          if (fwd_hit) hold2_d = l1.store_dat;
        end
      end
      SERIAL: begin
        // RAM output now carries lane 1's read from the previous cycle;
        // park it so the port is free for lane 2.
        acc_sel_l2 = 1'b1;
        hold1_d    = mem_rdata;
        wb1_d      = mk_wb(l1, 1'b1);
        wb2_d      = mk_wb(l2, 1'b0);
      end
      default: ;
    endcase
  end

  assign mem_addr  = acc_sel_l2 ? l2.alu_res[ADDR_W-1:0] : l1.alu_res[ADDR_W-1:0];
  assign mem_wdata = acc_sel_l2 ? l2.store_dat : l1.store_dat;
  // No writes while reset is held, so an interrupted bundle cannot finish its access.
  assign mem_we    = (acc_sel_l2 ? l2.mem_wr : l1.mem_wr) & ~rst;

  dmem_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.stall_o = stall & ~rst;

  assign bus.aluRes1_MEM_fwd = l1.jal ? zext_ra(l1.ra) : l1.alu_res;
  assign bus.aluRes2_MEM_fwd = l2.jal ? zext_ra(l2.ra) : l2.alu_res;

  assign ld1 = wb1_q.use_hold ? hold1_q : mem_rdata;
  assign ld2 = wb2_q.use_hold ? hold2_q : mem_rdata;

  assign bus.regWrite1_WB = wb1_q.reg_wr;
  assign bus.regWrite2_WB = wb2_q.reg_wr;
  assign bus.writeReg1_WB = wb1_q.dest;
  assign bus.writeReg2_WB = wb2_q.dest;
  assign bus.jal1_WB      = wb1_q.jal;
  assign bus.jal2_WB      = wb2_q.jal;
  assign bus.aluRes1_WB   = wb1_q.alu_res;
  assign bus.aluRes2_WB   = wb2_q.alu_res;

  // jal wins over MemtoReg.
  assign bus.writeData1_WB = wb1_q.jal ? zext_ra(wb1_q.ra) :
                             wb1_q.mem_to_reg ? ld1 : wb1_q.alu_res;
  assign bus.writeData2_WB = wb2_q.jal ? zext_ra(wb2_q.ra) :
                             wb2_q.mem_to_reg ? ld2 : wb2_q.alu_res;

endmodule
